pipeline_stage_elastic: RTL

//  Parametrised elastic pipeline register between adjacent CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_stage_elastic.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipeline_stage_elastic.sv
// rtl/pipeline_stage_elastic.sv - elastic valid/ready pipeline register with optional 2-entry skid
module pipeline_stage_elastic #(
    parameter int                CTRL_W      = 32,
    parameter int                DATA_W      = 192,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter bit                SKID        = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    // Occupancy doubles as the state: the number of entries currently held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic [DATA_W-1:0] r_m_data;

    logic w_m_v;
    logic w_in_fire;
    logic w_out_fire;

    assign w_m_v      = (r_state != ST_EMPTY);
    assign w_in_fire  = valid_i & ready_o;
    assign w_out_fire = w_m_v & ready_i;

    // Main entry always drives the outputs; ctrl is forced to the bubble
    // word when empty so a stale or unknown control word never leaks out.
    assign valid_o = w_m_v;
    assign ctrl_o  = w_m_v ? r_m_ctrl : CTRL_BUBBLE;
    assign data_o  = r_m_data;
    assign count_o = r_state;

    generate
        if (SKID) begin : g_skid
            logic [CTRL_W-1:0] r_s_ctrl;
            logic [DATA_W-1:0] r_s_data;

            // Ready depends only on state, so ready_i never reaches ready_o.
            assign ready_o = (r_state != ST_FULL);

            // Two-entry FSM: the skid entry absorbs the one word that was in
            // flight when downstream stalled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state  <= ST_EMPTY;
                    r_m_ctrl <= CTRL_BUBBLE;
                    r_m_data <= '0;
                    r_s_ctrl <= CTRL_BUBBLE;
                    r_s_data <= '0;
                end else if (flush_i) begin
                    r_state  <= ST_EMPTY;
                    r_m_ctrl <= CTRL_BUBBLE;
                    r_s_ctrl <= CTRL_BUBBLE;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in_fire) begin
                                r_state  <= ST_ONE;
                                r_m_ctrl <= ctrl_i;
                                r_m_data <= data_i;
                            end
                        end
                        ST_ONE: begin
                            if (w_in_fire && w_out_fire) begin
                                r_m_ctrl <= ctrl_i;
                                r_m_data <= data_i;
                            end else if (w_in_fire) begin
                                r_state  <= ST_FULL;
                                r_s_ctrl <= ctrl_i;
                                r_s_data <= data_i;
                            end else if (w_out_fire) begin
                                r_state <= ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (w_out_fire) begin
                                r_state  <= ST_ONE;
                                r_m_ctrl <= r_s_ctrl;
                                r_m_data <= r_s_data;
                                r_s_ctrl <= CTRL_BUBBLE;
                            end
                        end
                        default: r_state <= ST_EMPTY;
                    endcase
                end
            end
        end else begin : g_single
            // Single entry can refill in the same cycle it drains.
            assign ready_o = ~w_m_v | ready_i;

            // Single-entry FSM: load on accept, drop to empty on drain only.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state  <= ST_EMPTY;
                    r_m_ctrl <= CTRL_BUBBLE;
                    r_m_data <= '0;
                end else if (flush_i) begin
                    r_state  <= ST_EMPTY;
                    r_m_ctrl <= CTRL_BUBBLE;
                end else if (w_in_fire) begin
                    r_state  <= ST_ONE;
                    r_m_ctrl <= ctrl_i;
                    r_m_data <= data_i;
                end else if (w_out_fire) begin
                    r_state <= ST_EMPTY;
                end
            end
        end
    endgenerate

endmodule
